div_issue_ctrl: RTL
===================

# div_issue_ctrl

Issue/retire controller that sits directly upstream of the 65-bit multi-cycle non-restoring divider in the EX stage. It accepts RV64M divide-class instructions (DIV/DIVU/REM/REMU and their W forms) and latches the operands. It drives the divider's hold-until-ready handshake and selects quotient or remainder from the divider's 128-bit result, sign-extending W results. It then presents the result to the EX/MEM register via a valid/ready handshake, stalls the front end while busy, and drains in-flight divisions on flush.

## Interface
Parameters:
- XLEN, 64, operand/result width (only 64 supported).
- RD_W, 5, destination-register tag width.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high (hold ≥1 clk edge; the divider resets synchronously on the same net).
- ex_valid  in  1  EX holds a divide-class instruction; held until accepted.
- ex_funct3  in  3  RISC-V funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ex_is_w  in  1  W-form (32-bit) operation.
- ex_rs1, ex_rs2  in  XLEN  operands.
- ex_rd  in  RD_W  destination tag.
- flush  in  1  kill current instruction.
- stall_req  out  1  front-end stall.
- div_valid  out  1  to divider `valid`.
- div_sign  out  1  to divider.
- div_32  out  1  to divider.
- div_rs1, div_rs2  out  XLEN  to divider.
- div_ready  in  1  from divider.
- div_result  in  128  from divider, {rem[63:0], quot[63:0]}.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_data  out  XLEN  final result.
- out_rd  out  RD_W  tag of result.

## Operation
- FSM states: IDLE, BUSY, DRAIN, DONE.
- IDLE → BUSY on ex_valid & ~flush. Latch rs1, rs2, rd, is_rem = funct3[1], sign = ~funct3[0], is_w.
- BUSY: div_valid=1 and div_* driven from latched registers, stable every cycle.
  - On div_ready & ~flush: capture the formatted result into out_data/out_rd, → DONE.
  - On flush without div_ready: → DRAIN.
  - On flush & div_ready in the same cycle: → IDLE, result dropped.
- DRAIN: div_valid=1, because the divider cannot be aborted and freezes mid-count if valid drops. On div_ready → IDLE, result discarded. New ex_valid is not accepted in DRAIN.
- DONE: out_valid=1, div_valid=0.
  - out_ready → IDLE.
  - flush → IDLE, no handshake.
  - out_ready & flush: flush wins, no transfer.
- Result format:
  - sel = is_rem ? div_result[127:64] : div_result[63:0].
  - is_w → out_data = {{32{sel[31]}}, sel[31:0]}; else out_data = sel.
  - Divide-by-zero and overflow values come from the divider unchanged.
- stall_req = (IDLE & ex_valid & ~flush) | BUSY | (DRAIN & ex_valid) | (DONE & ~out_ready & ~flush).
- div_valid is deasserted in the cycle after div_ready, so the divider never restarts spuriously.

## Timing
- Reset values: state IDLE; stall_req 0; div_valid 0; div_sign 0; div_32 0; div_rs1/div_rs2 0; out_valid 0; out_data 0; out_rd 0.
- Normal divide, accept at cycle T:
  - div_valid high from T+1.
  - Divider ready at T+67 (counter 66).
  - out_valid at T+68.
- Divide-by-zero/overflow: divider ready combinationally at T+1, out_valid at T+2.
- Back-to-back ops: out_ready at cycle D gives IDLE at D+1; the next accept is at D+1 at the earliest.
- Reset mid-BUSY: all state and outputs return to reset values immediately. The divider clears at the next clk edge.

## Structure
- Add to `defines.v`:
  - funct3 constants DIV/DIVU/REM/REMU.
  - State encodings (2-bit): DIVC_IDLE, DIVC_BUSY, DIVC_DRAIN, DIVC_DONE.
  - `REG_BUS` reuse for XLEN.
- One sub-module, div_result_fmt: combinational quot/rem select plus W sign-extension (inputs div_result, is_rem, is_w; output XLEN).

## Test plan
- DIV −7/2, 64-bit, accept at T → out_valid at T+68, out_data 0xFFFF_FFFF_FFFF_FFFD. REM same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVW rs1=0x0000_0000_8000_0000, rs2=0xFFFF_FFFF_FFFF_FFFF (overflow) → out_valid at T+2, out_data 0xFFFF_FFFF_8000_0000. REMW same operands → 0.
- DIVU x/0 → out_data all ones at T+2. REMUW rs1=0x1_8000_0001, rs2=0 → 0xFFFF_FFFF_8000_0001.
- Flush at T+10 during BUSY → state DRAIN, div_valid held until T+67, no out_valid. A new DIVU offered at T+11 is accepted only at T+68.
- out_ready held low for 5 cycles after DONE → out_valid and out_data stable, stall_req high. Then out_ready=1 → IDLE next cycle, with div_valid never re-asserted in between.
- rst pulse at T+30 → all outputs 0 immediately. A fresh DIV after release completes with correct result and latency 68.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divide issue/retire controller.
//   - funct3 encodings of the RV64M divide class
//   - controller state encoding (2-bit)
//   - REG_BUS: register/operand width reused as XLEN
package div_issue_ctrl_pkg;

    localparam int unsigned REG_BUS   = 64;
    localparam int unsigned DIV_RES_W = 2 * REG_BUS;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIVC_IDLE  = 2'b00,
        DIVC_BUSY  = 2'b01,
        DIVC_DRAIN = 2'b10,
        DIVC_DONE  = 2'b11
    } divc_state_e;

    // funct3[1] selects remainder, funct3[0] selects unsigned.
    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[1];
    endfunction

    function automatic logic f3_is_signed(input logic [2:0] f3);
        return ~f3[0];
    endfunction

endpackage

// File: rtl/div_result_fmt.sv
// Result formatter for the divider output.
//   div_result : {rem, quot} from the divider (2*XLEN bits)
//   is_rem     : 1 selects the remainder half, 0 the quotient half
//   is_w       : 1 sign-extends bit 31 of the selection (W-form ops)
//   fmt_data   : formatted XLEN-bit result
module div_result_fmt
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = REG_BUS
) (
    input  logic [2*XLEN-1:0] div_result,
    input  logic              is_rem,
    input  logic              is_w,
    output logic [XLEN-1:0]   fmt_data
);

    logic [XLEN-1:0] sel;

    always_comb begin
        sel      = is_rem ? div_result[2*XLEN-1:XLEN] : div_result[XLEN-1:0];
        fmt_data = is_w ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/retire controller in front of the multi-cycle divider.
//   clk, rst              : clock, asynchronous active-high reset
//   ex_*                  : divide-class instruction offered by EX (held until accepted)
//   flush                 : kill the instruction in flight
//   stall_req             : front-end stall
//   div_valid/sign/32/rs* : hold-until-ready request to the divider
//   div_ready, div_result : divider completion and {rem, quot}
//   out_valid/ready/data/rd : result handshake towards EX/MEM
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = REG_BUS,
    parameter int unsigned RD_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_is_w,
    input  logic [XLEN-1:0]   ex_rs1,
    input  logic [XLEN-1:0]   ex_rs2,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic              flush,
    output logic              stall_req,
    output logic              div_valid,
    output logic              div_sign,
    output logic              div_32,
    output logic [XLEN-1:0]   div_rs1,
    output logic [XLEN-1:0]   div_rs2,
    input  logic              div_ready,
    input  logic [2*XLEN-1:0] div_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [RD_W-1:0]   out_rd
);

    divc_state_e     state_q, state_d;
    logic [XLEN-1:0] rs1_q, rs2_q, out_data_q;
    logic [RD_W-1:0] rd_q, out_rd_q;
    logic            is_rem_q, sign_q, is_w_q;
    logic            load_op, load_out;
    logic [XLEN-1:0] fmt_data;

    // funct3[2] is always set for the divide class; not needed for decode.
    logic unused_funct3;
    assign unused_funct3 = ex_funct3[2];

    div_result_fmt #(
        .XLEN (XLEN)
    ) u_fmt (
        .div_result (div_result),
        .is_rem     (is_rem_q),
        .is_w       (is_w_q),
        .fmt_data   (fmt_data)
    );

    always_comb begin
        state_d   = state_q;
        load_op   = 1'b0;
        load_out  = 1'b0;
        stall_req = 1'b0;
        div_valid = 1'b0;
        unique case (state_q)
            DIVC_IDLE: begin
                if (ex_valid && !flush) begin
                    state_d   = DIVC_BUSY;
                    load_op   = 1'b1;
                    stall_req = 1'b1;
                end
            end
            DIVC_BUSY: begin
                div_valid = 1'b1;
                stall_req = 1'b1;
                if (div_ready && !flush) begin
                    load_out = 1'b1;
                    state_d  = DIVC_DONE;
                end else if (flush) begin
                    state_d = div_ready ? DIVC_IDLE : DIVC_DRAIN;
                end
            end
            DIVC_DRAIN: begin
                // The divider cannot be aborted; keep valid high until it finishes.
                div_valid = 1'b1;
                stall_req = ex_valid;
                if (div_ready) begin
                    state_d = DIVC_IDLE;
                end
            end
            DIVC_DONE: begin
                stall_req = !out_ready && !flush;
                if (flush || out_ready) begin
                    state_d = DIVC_IDLE;
                end
            end
            default: state_d = DIVC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DIVC_IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            is_rem_q   <= 1'b0;
            sign_q     <= 1'b0;
            is_w_q     <= 1'b0;
            out_data_q <= '0;
            out_rd_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_op) begin
                rs1_q    <= ex_rs1;
                rs2_q    <= ex_rs2;
                rd_q     <= ex_rd;
                is_rem_q <= f3_is_rem(ex_funct3);
                sign_q   <= f3_is_signed(ex_funct3);
                is_w_q   <= ex_is_w;
            end
            if (load_out) begin
                out_data_q <= fmt_data;
                out_rd_q   <= rd_q;
            end
        end
    end

    assign div_sign  = sign_q;
    assign div_32    = is_w_q;
    assign div_rs1   = rs1_q;
    assign div_rs2   = rs2_q;
    assign out_valid = (state_q == DIVC_DONE);
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;

endmodule
